// File: rtl/reg_bus_master.sv
// Command-to-register-bus sequencer: one setup cycle, a one-cycle strobe, an optional
// read-latency wait, then a held response. All outputs are registered.
module reg_bus_master #(
   parameter int unsigned            ADDR_WIDTH = 4,
   parameter int unsigned            DATA_WIDTH = 8,
   parameter logic [ADDR_WIDTH-1:0]  IDLE_ADDR  = 4'hF,
   parameter int unsigned            RD_LATENCY = 1
) (
   input  logic                  i_clk,
   input  logic                  i_reset,
   input  logic                  i_cmd_valid,
   output logic                  o_cmd_ready,
   input  logic                  i_cmd_write,
   input  logic [ADDR_WIDTH-1:0] i_cmd_addr,
   input  logic [DATA_WIDTH-1:0] i_cmd_wdata,
   output logic                  o_rsp_valid,
   input  logic                  i_rsp_ready,
   output logic                  o_rsp_write,
   output logic [DATA_WIDTH-1:0] o_rsp_rdata,
   output logic [ADDR_WIDTH-1:0] o_reg_address,
   output logic                  o_reg_write_en,
   output logic                  o_reg_read_en,
   output logic [DATA_WIDTH-1:0] o_reg_wdata,
   input  logic [DATA_WIDTH-1:0] i_reg_rdata
);

   typedef enum logic [2:0] {
      StIdle,
      StSetup,
      StStrobe,
      StWait,
      StResp
   } state_e;

   state_e                r_state;
   state_e                w_state_next;

   logic                  r_cmd_write,    w_cmd_write_next;
   logic [ADDR_WIDTH-1:0] r_cmd_addr,     w_cmd_addr_next;
   logic [DATA_WIDTH-1:0] r_cmd_wdata,    w_cmd_wdata_next;
   logic [2:0]            r_wait_cnt,     w_wait_cnt_next;

   logic                  r_cmd_ready,    w_cmd_ready_next;
   logic                  r_rsp_valid,    w_rsp_valid_next;
   logic                  r_rsp_write,    w_rsp_write_next;
   logic [DATA_WIDTH-1:0] r_rsp_rdata,    w_rsp_rdata_next;
   logic [ADDR_WIDTH-1:0] r_reg_address,  w_reg_address_next;
   logic                  r_reg_write_en, w_reg_write_en_next;
   logic                  r_reg_read_en,  w_reg_read_en_next;
   logic [DATA_WIDTH-1:0] r_reg_wdata,    w_reg_wdata_next;

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state        <= StIdle;
         r_cmd_write    <= 1'b0;
         r_cmd_addr     <= '0;
         r_cmd_wdata    <= '0;
         r_wait_cnt     <= '0;
         r_cmd_ready    <= 1'b0;
         r_rsp_valid    <= 1'b0;
         r_rsp_write    <= 1'b0;
         r_rsp_rdata    <= '0;
         r_reg_address  <= IDLE_ADDR;
         r_reg_write_en <= 1'b0;
         r_reg_read_en  <= 1'b0;
         r_reg_wdata    <= '0;
      end else begin
         r_state        <= w_state_next;
         r_cmd_write    <= w_cmd_write_next;
         r_cmd_addr     <= w_cmd_addr_next;
         r_cmd_wdata    <= w_cmd_wdata_next;
         r_wait_cnt     <= w_wait_cnt_next;
         r_cmd_ready    <= w_cmd_ready_next;
         r_rsp_valid    <= w_rsp_valid_next;
         r_rsp_write    <= w_rsp_write_next;
         r_rsp_rdata    <= w_rsp_rdata_next;
         r_reg_address  <= w_reg_address_next;
         r_reg_write_en <= w_reg_write_en_next;
         r_reg_read_en  <= w_reg_read_en_next;
         r_reg_wdata    <= w_reg_wdata_next;
      end
   end

   // Each branch computes the registered outputs for the state being entered.
   always_comb begin
      w_state_next        = r_state;
      w_cmd_write_next    = r_cmd_write;
      w_cmd_addr_next     = r_cmd_addr;
      w_cmd_wdata_next    = r_cmd_wdata;
      w_wait_cnt_next     = r_wait_cnt;
      w_rsp_valid_next    = 1'b0;
      w_rsp_write_next    = r_rsp_write;
      w_rsp_rdata_next    = r_rsp_rdata;
      w_reg_address_next  = IDLE_ADDR;
      w_reg_write_en_next = 1'b0;
      w_reg_read_en_next  = 1'b0;
      w_reg_wdata_next    = '0;

      unique case (r_state)
         StIdle: begin
            if (i_cmd_valid && r_cmd_ready) begin
               w_cmd_write_next   = i_cmd_write;
               w_cmd_addr_next    = i_cmd_addr;
               w_cmd_wdata_next   = i_cmd_wdata;
               w_reg_address_next = i_cmd_addr;
               w_state_next       = StSetup;
            end
         end
         StSetup: begin
            w_reg_address_next  = r_cmd_addr;
            w_reg_write_en_next = r_cmd_write;
            w_reg_read_en_next  = ~r_cmd_write;
            w_reg_wdata_next    = r_cmd_write ? r_cmd_wdata : '0;
            w_state_next        = StStrobe;
         end
         StStrobe: begin
            if (r_cmd_write) begin
               w_rsp_valid_next = 1'b1;
               w_rsp_write_next = 1'b1;
               w_rsp_rdata_next = '0;
               w_state_next     = StResp;
            end else begin
               w_wait_cnt_next  = 3'(RD_LATENCY);
               w_state_next     = StWait;
            end
         end
         StWait: begin
            if (r_wait_cnt == 3'd1) begin
               w_rsp_valid_next = 1'b1;
               w_rsp_write_next = 1'b0;
               w_rsp_rdata_next = i_reg_rdata;
               w_state_next     = StResp;
            end else begin
               w_wait_cnt_next  = r_wait_cnt - 3'd1;
            end
         end
         StResp: begin
            if (i_rsp_ready) begin
               w_state_next     = StIdle;
            end else begin
               w_rsp_valid_next = 1'b1;
            end
         end
         default: w_state_next = StIdle;
      endcase

      w_cmd_ready_next = (w_state_next == StIdle);
   end

   assign o_cmd_ready    = r_cmd_ready;
   assign o_rsp_valid    = r_rsp_valid;
   assign o_rsp_write    = r_rsp_write;
   assign o_rsp_rdata    = r_rsp_rdata;
   assign o_reg_address  = r_reg_address;
   assign o_reg_write_en = r_reg_write_en;
   assign o_reg_read_en  = r_reg_read_en;
   assign o_reg_wdata    = r_reg_wdata;

endmodule

// File: tb/tb_reg_bus_master.sv
// Directed bench for reg_bus_master: two instances (read latency 1 and 3), each driving a
// small register-block model; responses are checked against a queue of expected results.
module tb_reg_bus_master;

   typedef struct packed {
      logic       write;
      logic [7:0] rdata;
   } rsp_t;

   logic       clk = 1'b0;
   logic       reset;
   logic       cmd_valid     [2];
   logic       cmd_ready     [2];
   logic       cmd_write     [2];
   logic [3:0] cmd_addr      [2];
   logic [7:0] cmd_wdata     [2];
   logic       rsp_valid     [2];
   logic       rsp_ready     [2];
   logic       rsp_write     [2];
   logic [7:0] rsp_rdata     [2];
   logic [3:0] reg_address   [2];
   logic       reg_write_en  [2];
   logic       reg_read_en   [2];
   logic [7:0] reg_wdata     [2];
   logic [7:0] reg_rdata     [2];

   int checks = 0;
   int errors = 0;

   rsp_t       exp_q [$];
   logic [7:0] shadow [2][16];
   int         exp_wr [2] = '{0, 0};
   int         exp_rd [2] = '{0, 0};

   // register-block model state
   logic [7:0] mem       [2][16];
   int         rd_cnt    [2] = '{0, 0};
   logic [3:0] rd_addr   [2] = '{4'h0, 4'h0};
   int         wr_pulses [2] = '{0, 0};
   int         rd_pulses [2] = '{0, 0};

   always #5 clk = ~clk;

   function automatic int lat_of(input int d);
      return (d == 0) ? 1 : 3;
   endfunction

   reg_bus_master #(.RD_LATENCY(1)) u_dut0 (
      .i_clk          (clk),
      .i_reset        (reset),
      .i_cmd_valid    (cmd_valid[0]),
      .o_cmd_ready    (cmd_ready[0]),
      .i_cmd_write    (cmd_write[0]),
      .i_cmd_addr     (cmd_addr[0]),
      .i_cmd_wdata    (cmd_wdata[0]),
      .o_rsp_valid    (rsp_valid[0]),
      .i_rsp_ready    (rsp_ready[0]),
      .o_rsp_write    (rsp_write[0]),
      .o_rsp_rdata    (rsp_rdata[0]),
      .o_reg_address  (reg_address[0]),
      .o_reg_write_en (reg_write_en[0]),
      .o_reg_read_en  (reg_read_en[0]),
      .o_reg_wdata    (reg_wdata[0]),
      .i_reg_rdata    (reg_rdata[0])
   );

   reg_bus_master #(.RD_LATENCY(3)) u_dut3 (
      .i_clk          (clk),
      .i_reset        (reset),
      .i_cmd_valid    (cmd_valid[1]),
      .o_cmd_ready    (cmd_ready[1]),
      .i_cmd_write    (cmd_write[1]),
      .i_cmd_addr     (cmd_addr[1]),
      .i_cmd_wdata    (cmd_wdata[1]),
      .o_rsp_valid    (rsp_valid[1]),
      .i_rsp_ready    (rsp_ready[1]),
      .o_rsp_write    (rsp_write[1]),
      .o_rsp_rdata    (rsp_rdata[1]),
      .o_reg_address  (reg_address[1]),
      .o_reg_write_en (reg_write_en[1]),
      .o_reg_read_en  (reg_read_en[1]),
      .o_reg_wdata    (reg_wdata[1]),
      .i_reg_rdata    (reg_rdata[1])
   );

   // Read data is valid only in the exact cycle the master should sample it.
   always @(posedge clk) begin
      for (int i = 0; i < 2; i++) begin
         if (reg_write_en[i]) begin
            mem[i][reg_address[i]] <= reg_wdata[i];
            wr_pulses[i]           <= wr_pulses[i] + 1;
         end
         if (reg_read_en[i]) begin
            rd_cnt[i]    <= lat_of(i);
            rd_addr[i]   <= reg_address[i];
            rd_pulses[i] <= rd_pulses[i] + 1;
         end else if (rd_cnt[i] > 0) begin
            rd_cnt[i] <= rd_cnt[i] - 1;
         end
      end
   end

   always_comb begin
      for (int i = 0; i < 2; i++) begin
         reg_rdata[i] = (rd_cnt[i] == 1) ? mem[i][rd_addr[i]] : 8'hEE;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // hold < 0: rsp_ready raised before rsp_valid; hold > 0: backpressure cycles.
   task automatic do_cmd(input int d, input logic wr, input logic [3:0] a, input logic [7:0] wd,
                         input int hold);
      rsp_t       e;
      int         n;
      int         cyc;
      logic       w0;
      logic [7:0] rd0;
      cmd_valid[d] = 1'b1;
      cmd_write[d] = wr;
      cmd_addr[d]  = a;
      cmd_wdata[d] = wd;
      if (hold < 0) rsp_ready[d] = 1'b1;
      n = 0;
      while (cmd_ready[d] !== 1'b1 && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk("cmd_ready_seen", {31'd0, cmd_ready[d]}, 32'd1);
      e.write = wr;
      e.rdata = wr ? 8'h00 : shadow[d][a];
      exp_q.push_back(e);
      if (wr) shadow[d][a] = wd;

      @(negedge clk);
      cmd_valid[d] = 1'b0;
      chk("c1_addr", {28'd0, reg_address[d]}, {28'd0, a});
      chk("c1_strobes", {30'd0, reg_write_en[d], reg_read_en[d]}, 32'd0);
      chk("c1_wdata", {24'd0, reg_wdata[d]}, 32'd0);
      chk("c1_cmd_ready", {31'd0, cmd_ready[d]}, 32'd0);

      @(negedge clk);
      chk("c2_addr", {28'd0, reg_address[d]}, {28'd0, a});
      chk("c2_strobes", {30'd0, reg_write_en[d], reg_read_en[d]}, wr ? 32'd2 : 32'd1);
      chk("c2_wdata", {24'd0, reg_wdata[d]}, wr ? {24'd0, wd} : 32'd0);
      if (wr) exp_wr[d]++;
      else    exp_rd[d]++;

      cyc = 2;
      do begin
         @(negedge clk);
         cyc++;
         chk("parked_bus", {18'd0, reg_address[d], reg_write_en[d], reg_read_en[d], reg_wdata[d]},
             {18'd0, 4'hF, 2'b00, 8'h00});
      end while (rsp_valid[d] !== 1'b1 && cyc < 20);
      chk("rsp_cycle", cyc, wr ? 32'd3 : 32'(3 + lat_of(d)));

      w0  = rsp_write[d];
      rd0 = rsp_rdata[d];
      for (int k = 0; k < hold; k++) begin
         @(negedge clk);
         chk("bp_valid", {31'd0, rsp_valid[d]}, 32'd1);
         chk("bp_fields", {23'd0, rsp_write[d], rsp_rdata[d]}, {23'd0, w0, rd0});
         chk("bp_cmd_ready", {31'd0, cmd_ready[d]}, 32'd0);
         chk("bp_strobes", {30'd0, reg_write_en[d], reg_read_en[d]}, 32'd0);
      end
      rsp_ready[d] = 1'b1;
      chk("rsp_valid_held", {31'd0, rsp_valid[d]}, 32'd1);
      chk("sb_nonempty", {31'd0, exp_q.size() != 0}, 32'd1);
      if (exp_q.size() != 0) begin
         e = exp_q.pop_front();
         chk("rsp_write", {31'd0, rsp_write[d]}, {31'd0, e.write});
         chk("rsp_rdata", {24'd0, rsp_rdata[d]}, {24'd0, e.rdata});
      end

      @(negedge clk);
      rsp_ready[d] = 1'b0;
      chk("rsp_dropped", {31'd0, rsp_valid[d]}, 32'd0);
      chk("ready_after_rsp", {31'd0, cmd_ready[d]}, 32'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1;
      for (int i = 0; i < 2; i++) begin
         cmd_valid[i] = 1'b0;
         cmd_write[i] = 1'b0;
         cmd_addr[i]  = 4'h0;
         cmd_wdata[i] = 8'h00;
         rsp_ready[i] = 1'b0;
      end

      repeat (3) @(negedge clk);
      chk("rst_cmd_ready", {31'd0, cmd_ready[0]}, 32'd0);
      chk("rst_addr", {28'd0, reg_address[0]}, 32'hF);
      chk("rst_strobes", {30'd0, reg_write_en[0], reg_read_en[0]}, 32'd0);
      chk("rst_rsp", {22'd0, rsp_valid[0], rsp_write[0], rsp_rdata[0]}, 32'd0);
      reset = 1'b0;
      @(negedge clk);
      chk("rel_cmd_ready", {31'd0, cmd_ready[0]}, 32'd1);
      chk("rel_cmd_ready3", {31'd0, cmd_ready[1]}, 32'd1);

      do_cmd(0, 1'b1, 4'h0, 8'hA5, 0);
      do_cmd(0, 1'b1, 4'h1, 8'hA6, -1);
      do_cmd(0, 1'b1, 4'h2, 8'hA7, 2);
      do_cmd(0, 1'b1, 4'h3, 8'hA8, 0);
      do_cmd(0, 1'b0, 4'h0, 8'h00, 0);
      do_cmd(0, 1'b0, 4'h1, 8'h33, -1);
      do_cmd(0, 1'b0, 4'h2, 8'h00, 5);
      do_cmd(0, 1'b0, 4'h3, 8'h00, 0);

      // reset asserted while the write strobe is on the bus
      cmd_valid[0] = 1'b1;
      cmd_write[0] = 1'b1;
      cmd_addr[0]  = 4'h3;
      cmd_wdata[0] = 8'h5C;
      @(negedge clk);
      cmd_valid[0] = 1'b0;
      @(negedge clk);
      chk("abort_strobe_on", {31'd0, reg_write_en[0]}, 32'd1);
      exp_wr[0]++;
      shadow[0][3] = 8'h5C;
      reset = 1'b1;
      @(negedge clk);
      chk("abort_strobe_off", {30'd0, reg_write_en[0], reg_read_en[0]}, 32'd0);
      chk("abort_no_rsp", {31'd0, rsp_valid[0]}, 32'd0);
      chk("abort_addr", {28'd0, reg_address[0]}, 32'hF);
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      chk("abort_ready", {31'd0, cmd_ready[0]}, 32'd1);
      chk("abort_no_rsp2", {31'd0, rsp_valid[0]}, 32'd0);
      chk("abort_q_empty", exp_q.size(), 32'd0);
      do_cmd(0, 1'b0, 4'h3, 8'h00, 0);

      do_cmd(1, 1'b1, 4'h1, 8'hA6, 0);
      do_cmd(1, 1'b0, 4'h1, 8'h00, 1);

      repeat (2) @(negedge clk);
      chk("wr_pulses0", wr_pulses[0], exp_wr[0]);
      chk("rd_pulses0", rd_pulses[0], exp_rd[0]);
      chk("wr_pulses3", wr_pulses[1], exp_wr[1]);
      chk("rd_pulses3", rd_pulses[1], exp_rd[1]);
      chk("q_empty", exp_q.size(), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
